// File: rtl/eth_idma_desc_fifo_if.sv
// Backend-side handshake bundle between the descriptor FIFO and the iDMA 1D backend.
// The FIFO uses the master modport; the backend (or a bench) uses the slave modport.
interface eth_idma_desc_fifo_if #(
  parameter int unsigned ReqWidth = 128
);
  logic                req_valid_o;
  logic [ReqWidth-1:0] req_o;
  logic                req_ready_i;
  logic                rsp_valid_i;
  logic                rsp_error_i;
  logic                rsp_ready_o;

  modport master (
    output req_valid_o, req_o, rsp_ready_o,
    input  req_ready_i, rsp_valid_i, rsp_error_i
  );

  modport slave (
    input  req_valid_o, req_o, rsp_ready_o,
    output req_ready_i, rsp_valid_i, rsp_error_i
  );
endinterface

// File: rtl/eth_idma_desc_fifo.sv
// Descriptor FIFO between the register file and the iDMA backend.
// It caps the number of outstanding descriptors and tracks completions and sticky errors.
module eth_idma_desc_fifo #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned ReqWidth    = 128,
  parameter int unsigned MaxInflight = 3,
  localparam int unsigned InflW      = $clog2(MaxInflight + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [ReqWidth-1:0]    push_req_i,
  output logic                   full_o,
  eth_idma_desc_fifo_if.master   be,
  input  logic                   err_clr_i,
  output logic [InflW-1:0]       inflight_o,
  output logic [15:0]            done_cnt_o,
  output logic                   overflow_o,
  output logic                   rsp_err_o,
  output logic                   spurious_o,
  output logic                   idle_o,
  output logic                   irq_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth + 1);

  logic [ReqWidth-1:0] mem [Depth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [OccW-1:0]     occ_q, occ_d;
  logic [InflW-1:0]    infl_q, infl_d;
  logic [15:0]         done_q;
  logic                ovf_q, rerr_q, spur_q, full_q, idle_q, irq_q;
  logic                req_valid, push_ok, issue, rsp_cnt;
  logic                ovf_set, rerr_set, spur_set;

  assign req_valid      = (occ_q != '0) && (infl_q < InflW'(MaxInflight));
  assign be.req_valid_o = req_valid;
  assign be.req_o       = mem[rptr_q];
  assign be.rsp_ready_o = 1'b1;

  always_comb begin
    // Full is judged on the registered occupancy, so a same-cycle pop never rescues a push.
    push_ok  = push_i && (occ_q != OccW'(Depth));
    issue    = req_valid && be.req_ready_i;
    rsp_cnt  = be.rsp_valid_i && (infl_q != '0);
    ovf_set  = push_i && !push_ok;
    rerr_set = rsp_cnt && be.rsp_error_i;
    spur_set = be.rsp_valid_i && (infl_q == '0);
    occ_d    = occ_q + OccW'(push_ok) - OccW'(issue);
    infl_d   = infl_q + InflW'(issue) - InflW'(rsp_cnt);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr_q] <= push_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      infl_q <= '0;
      done_q <= '0;
      ovf_q  <= 1'b0;
      rerr_q <= 1'b0;
      spur_q <= 1'b0;
      full_q <= 1'b0;
      idle_q <= 1'b1;
      irq_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (issue)   rptr_q <= rptr_q + PtrW'(1);
      if (rsp_cnt) done_q <= done_q + 16'd1;
      occ_q  <= occ_d;
      infl_q <= infl_d;
      // Set events win over a coincident clear.
      ovf_q  <= ovf_set  | (ovf_q  & ~err_clr_i);
      rerr_q <= rerr_set | (rerr_q & ~err_clr_i);
      spur_q <= spur_set | (spur_q & ~err_clr_i);
      full_q <= (occ_d == OccW'(Depth));
      idle_q <= (occ_d == '0) && (infl_d == '0);
      irq_q  <= rsp_cnt && (occ_d == '0) && (infl_d == '0);
    end
  end

  assign full_o     = full_q;
  assign inflight_o = infl_q;
  assign done_cnt_o = done_q;
  assign overflow_o = ovf_q;
  assign rsp_err_o  = rerr_q;
  assign spurious_o = spur_q;
  assign idle_o     = idle_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_eth_idma_desc_fifo.sv
// Self-checking bench for eth_idma_desc_fifo: hand-computed vector table, directed
// corner sequences and randomized traffic against a queue-based reference model.
module tb_eth_idma_desc_fifo;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push;
  logic [127:0] push_req;
  logic         full;
  logic         err_clr;
  logic [1:0]   inflight;
  logic [15:0]  done;
  logic         ovf, rerr, spur, idle, irq;

  eth_idma_desc_fifo_if #(.ReqWidth(128)) be ();

  eth_idma_desc_fifo #(.Depth(4), .ReqWidth(128), .MaxInflight(3)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (push),
    .push_req_i (push_req),
    .full_o     (full),
    .be         (be),
    .err_clr_i  (err_clr),
    .inflight_o (inflight),
    .done_cnt_o (done),
    .overflow_o (ovf),
    .rsp_err_o  (rerr),
    .spurious_o (spur),
    .idle_o     (idle),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: descriptor queue, outstanding count, counters and flags.
  logic [127:0] mq[$];
  int           m_infl;
  logic [15:0]  m_done;
  bit           m_ovf, m_rerr, m_spur, m_irq;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit p, input logic [127:0] d, input bit rdy,
                       input bit rv, input bit re, input bit clr);
    push = p; push_req = d; be.req_ready_i = rdy;
    be.rsp_valid_i = rv; be.rsp_error_i = re; err_clr = clr;
  endtask

  task automatic check_model();
    bit mv;
    mv = (mq.size() > 0) && (m_infl < 3);
    chk("req_valid", be.req_valid_o, mv);
    if (mv) chk("req", be.req_o, mq[0]);
    chk("full", full, mq.size() == 4);
    chk("inflight", inflight, m_infl);
    chk("done_cnt", done, m_done);
    chk("overflow", ovf, m_ovf);
    chk("rsp_err", rerr, m_rerr);
    chk("spurious", spur, m_spur);
    chk("idle", idle, (mq.size() == 0) && (m_infl == 0));
    chk("irq", irq, m_irq);
    chk("rsp_ready", be.rsp_ready_o, 1'b1);
  endtask

  task automatic model_step();
    bit issue, counted;
    if (!rst_n) begin
      mq.delete(); m_infl = 0; m_done = '0;
      m_ovf = 0; m_rerr = 0; m_spur = 0; m_irq = 0;
      return;
    end
    issue   = (mq.size() > 0) && (m_infl < 3) && be.req_ready_i;
    counted = be.rsp_valid_i && (m_infl > 0);
    if (push && mq.size() == 4) m_ovf = 1; else if (err_clr) m_ovf = 0;
    if (counted && be.rsp_error_i) m_rerr = 1; else if (err_clr) m_rerr = 0;
    if (be.rsp_valid_i && m_infl == 0) m_spur = 1; else if (err_clr) m_spur = 0;
    if (push && mq.size() < 4) begin
      if (issue) void'(mq.pop_front());
      mq.push_back(push_req);
    end else if (issue) void'(mq.pop_front());
    m_infl = m_infl + int'(issue) - int'(counted);
    if (counted) m_done = m_done + 16'd1;
    m_irq = counted && (mq.size() == 0) && (m_infl == 0);
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit           p;
    logic [127:0] d;
    bit           rdy, rv, re, clr;
    bit           e_valid;
    logic [127:0] e_req;
    logic [1:0]   e_infl;
    bit           e_full, e_idle, e_irq;
    logic [15:0]  e_done;
    logic [2:0]   e_flags;   // {overflow, rsp_err, spurious}
  } vec_t;

  vec_t         vecs[11];
  logic [127:0] a, dq[5];
  int           guard;
  logic [15:0]  done_hold;

  initial begin
    a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    // Push A, stall 3 cycles, accept, error response, clear, spurious response.
    vecs[0]  = '{1, a, 0, 0, 0, 0,  0, '0, 2'd0, 0, 1, 0, 16'd0, 3'b000};
    vecs[1]  = '{0, '0, 0, 0, 0, 0, 1, a,  2'd0, 0, 0, 0, 16'd0, 3'b000};
    vecs[2]  = '{0, '0, 0, 0, 0, 0, 1, a,  2'd0, 0, 0, 0, 16'd0, 3'b000};
    vecs[3]  = '{0, '0, 0, 0, 0, 0, 1, a,  2'd0, 0, 0, 0, 16'd0, 3'b000};
    vecs[4]  = '{0, '0, 1, 0, 0, 0, 1, a,  2'd0, 0, 0, 0, 16'd0, 3'b000};
    vecs[5]  = '{0, '0, 0, 0, 0, 0, 0, '0, 2'd1, 0, 0, 0, 16'd0, 3'b000};
    vecs[6]  = '{0, '0, 0, 1, 1, 0, 0, '0, 2'd1, 0, 0, 0, 16'd0, 3'b000};
    vecs[7]  = '{0, '0, 0, 0, 0, 0, 0, '0, 2'd0, 0, 1, 1, 16'd1, 3'b010};
    vecs[8]  = '{0, '0, 0, 0, 0, 1, 0, '0, 2'd0, 0, 1, 0, 16'd1, 3'b010};
    vecs[9]  = '{0, '0, 0, 1, 0, 0, 0, '0, 2'd0, 0, 1, 0, 16'd1, 3'b000};
    vecs[10] = '{0, '0, 0, 0, 0, 0, 0, '0, 2'd0, 0, 1, 0, 16'd1, 3'b001};

    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_req_valid", be.req_valid_o, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_irq", irq, 1'b0);
    chk("rst_rsp_ready", be.rsp_ready_o, 1'b1);
    chk_en = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].p, vecs[i].d, vecs[i].rdy, vecs[i].rv, vecs[i].re, vecs[i].clr);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), be.req_valid_o, vecs[i].e_valid);
      if (vecs[i].e_valid) chk($sformatf("vec%0d_req", i), be.req_o, vecs[i].e_req);
      chk($sformatf("vec%0d_infl", i), inflight, vecs[i].e_infl);
      chk($sformatf("vec%0d_full", i), full, vecs[i].e_full);
      chk($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
      chk($sformatf("vec%0d_irq", i), irq, vecs[i].e_irq);
      chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("vec%0d_flags", i), {ovf, rerr, spur}, vecs[i].e_flags);
      @(posedge clk);
      model_step();
      #1;
    end

    // Overflow: five pushes into a stalled Depth=4 FIFO.
    drive(0, '0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      dq[i] = {$urandom, $urandom, $urandom, $urandom};
      drive(1, dq[i], 0, 0, 0, 0); tick();
      if (i == 3) chk("full_after_4", full, 1'b1);
    end
    drive(0, '0, 0, 0, 0, 0); tick();
    chk("overflow_set", ovf, 1'b1);
    chk("full_held", full, 1'b1);

    // Drain with ready high: three issue, then the inflight cap holds the fourth.
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 0, 0, 0);
      chk($sformatf("drain%0d_valid", i), be.req_valid_o, 1'b1);
      chk($sformatf("drain%0d_req", i), be.req_o, dq[i]);
      tick();
    end
    chk("cap_inflight", inflight, 2'd3);
    chk("cap_valid", be.req_valid_o, 1'b0);
    tick();
    chk("cap_valid_held", be.req_valid_o, 1'b0);
    drive(0, '0, 1, 1, 0, 0); tick();
    drive(0, '0, 1, 0, 0, 0);
    chk("fourth_valid", be.req_valid_o, 1'b1);
    chk("fourth_req", be.req_o, dq[3]);
    tick();
    drive(0, '0, 0, 0, 0, 0); tick();
    chk("fourth_issued", inflight, 2'd3);
    for (int i = 0; i < 3; i++) begin drive(0, '0, 0, 1, 0, 0); tick(); end
    drive(0, '0, 0, 0, 0, 0);
    chk("drain_irq", irq, 1'b1);
    chk("drain_idle", idle, 1'b1);
    tick();
    chk("drain_irq_once", irq, 1'b0);

    // Done counter wrap: stream push/issue/response every cycle.
    drive(1, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 1); tick();
    guard = 0;
    while (m_done != 16'hFFFF && guard < 70000) begin
      drive(1, {$urandom, $urandom, $urandom, $urandom}, 1, m_infl > 0, 0, 0);
      tick();
      guard++;
    end
    chk("wrap_reach_bound", guard < 70000, 1'b1);
    chk("done_ffff", done, 16'hFFFF);
    drive(0, '0, 1, 1, 0, 0); tick();
    chk("done_wrap", done, 16'h0000);

    // Drain completely, then a spurious response.
    guard = 0;
    while ((m_infl > 0 || mq.size() > 0) && guard < 20) begin
      drive(0, '0, 1, m_infl > 0, 0, 0); tick(); guard++;
    end
    chk("drain_bound", guard < 20, 1'b1);
    drive(0, '0, 0, 0, 0, 1); tick();
    done_hold = done;
    drive(0, '0, 0, 1, 1, 0); tick();
    drive(0, '0, 0, 0, 0, 0);
    chk("spurious_set", spur, 1'b1);
    chk("spurious_done", done, done_hold);
    chk("spurious_no_err", rerr, 1'b0);

    // Reset with two queued and two in flight.
    for (int i = 0; i < 4; i++) begin
      drive(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0); tick();
    end
    drive(0, '0, 1, 0, 0, 0); tick(); tick();
    drive(1, '0, 0, 0, 0, 0);
    chk("pre_rst_infl", inflight, 2'd2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    drive(0, '0, 0, 0, 0, 0);
    chk("post_rst_infl", inflight, 2'd0);
    chk("post_rst_idle", idle, 1'b1);
    chk("post_rst_valid", be.req_valid_o, 1'b0);
    chk("post_rst_flags", {ovf, rerr, spur, irq, full}, 5'b0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(2) == 0, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(1) == 1, $urandom_range(3) == 0,
            $urandom_range(1) == 1, $urandom_range(15) == 0);
      tick();
    end
    drive(0, '0, 0, 0, 0, 0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_idma_desc_fifo.md
ETH_IDMA_DESC_FIFO -- requirements
Module: eth_idma_desc_fifo

Interface
REQ-001 SHALL have parameter Depth, default 4, descriptor FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ReqWidth, default 128, flattened iDMA 1D request width in bits.
REQ-003 SHALL have parameter MaxInflight, default 3, maximum descriptors issued to the backend and not yet answered (>=1).
REQ-004 SHALL have port clk_i  in  1  single clock for all logic.
REQ-005 SHALL have port rst_ni  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port push_i  in  1  one-cycle launch strobe from the register file.
REQ-007 SHALL have port push_req_i  in  ReqWidth  descriptor captured on push_i.
REQ-008 SHALL have port full_o  out  1  FIFO holds Depth entries.
REQ-009 SHALL have port req_valid_o  out  1  descriptor offered to the iDMA backend.
REQ-010 SHALL have port req_o  out  ReqWidth  head descriptor.
REQ-011 SHALL have port req_ready_i  in  1  backend accepts the descriptor.
REQ-012 SHALL have port rsp_valid_i  in  1  backend response valid.
REQ-013 SHALL have port rsp_error_i  in  1  backend response error flag.
REQ-014 SHALL have port rsp_ready_o  out  1  response accepted.
REQ-015 SHALL have port err_clr_i  in  1  one-cycle clear of the sticky flags.
REQ-016 SHALL have port inflight_o  out  $clog2(MaxInflight+1)  issued, unanswered count.
REQ-017 SHALL have port done_cnt_o  out  16  completed responses, wrapping.
REQ-018 SHALL have ports overflow_o, rsp_err_o, spurious_o  out  1 each  sticky flags.
REQ-019 SHALL have port idle_o  out  1  FIFO empty and inflight_o==0.
REQ-020 SHALL have port irq_o  out  1  one-cycle completion pulse.

Function
REQ-021 SHALL store descriptors in a circular FIFO with wrapping read/write pointers and an occupancy counter 0..Depth.
REQ-022 SHALL accept a push when push_i=1 and occupancy<Depth at that cycle; a push while full SHALL be dropped and set overflow_o, even if a pop occurs the same cycle.
REQ-023 SHALL give one-cycle push-to-req_valid_o latency; there is no combinational bypass from push_req_i to req_o.
REQ-024 SHALL drive req_valid_o = (occupancy>0) && (inflight<MaxInflight), with req_o equal to the head entry.
REQ-025 SHALL hold req_o stable while req_valid_o=1 and req_ready_i=0; pop and inflight increment SHALL occur only on req_valid_o&&req_ready_i.
REQ-026 SHALL drive rsp_ready_o=1 constantly; a response handshake is rsp_valid_i=1.
REQ-027 on a response with inflight>0: SHALL decrement inflight and increment done_cnt_o mod 2^16; rsp_error_i=1 SHALL set rsp_err_o.
REQ-028 on a response with inflight==0: SHALL set spurious_o and leave inflight and done_cnt_o unchanged.
REQ-029 SHALL leave inflight unchanged when an issue and a valid response coincide; done_cnt_o still increments.
REQ-030 SHALL allow a simultaneous push and pop with occupancy in 1..Depth-1, leaving occupancy unchanged.
REQ-031 SHALL pulse irq_o for exactly one cycle, the cycle after a counted response that leaves occupancy==0 and inflight==0.
REQ-032 SHALL clear all sticky flags with err_clr_i; a set event in the same cycle SHALL take priority.
REQ-033 SHALL register all outputs except req_valid_o, req_o and rsp_ready_o, which are decoded from registered state.

Reset
REQ-034 while rst_ni=0 at a clock edge: SHALL empty the FIFO and clear pointers, inflight, done_cnt_o, sticky flags and irq_o; descriptor storage need not be reset.
REQ-035 during and after reset: SHALL drive req_valid_o=0, full_o=0, idle_o=1, irq_o=0 and rsp_ready_o=1, with in-flight backend transactions forgotten.

Verification
REQ-036 Push A (req_ready_i=0 for 3 cycles) -> req_valid_o=1 from the cycle after the push, req_o=A stable; on ready, inflight_o=1 and the FIFO is empty.
REQ-037 Five pushes, Depth=4, backend stalled -> full_o=1 after the 4th push, 5th dropped, overflow_o=1; drain order A,B,C,D.
REQ-038 Four descriptors, req_ready_i=1, no responses -> exactly 3 issued, req_valid_o=0 while inflight_o=3; one response -> 4th issues the next cycle.
REQ-039 Response with rsp_error_i=1 on the last outstanding descriptor, FIFO empty -> done_cnt_o+1, rsp_err_o=1, irq_o high one cycle, idle_o=1.
REQ-040 rsp_valid_i with inflight_o=0 -> spurious_o=1, done_cnt_o unchanged; done_cnt_o=16'hFFFF plus one response -> 16'h0000.
REQ-041 Reset asserted with 2 queued and 2 in flight -> next cycle occupancy 0, inflight_o=0, idle_o=1, all flags 0.
